// File: rtl/lcm_from_gcd.sv
// -----------------------------------------------------------------------------
// lcm_from_gcd
// Downstream stage of the GCD unit: lcm = (op_a / gcd) * op_b, computed with a
// sequential restoring divide (W cycles) followed by a shift-add multiply
// (W cycles).
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   load       in   operand strobe (same cycle as the GCD unit's Begin)
//   op_a       in   W   operand a, sampled on an accepted load
//   op_b       in   W   operand b, sampled on an accepted load
//   gcd_valid  in   GCD unit Complete (may be high for 2 cycles)
//   gcd_in     in   W   gcd result, valid while gcd_valid=1
//   busy       out  high in WAIT_GCD, DIV and MUL
//   done       out  one-cycle pulse when lcm is valid
//   lcm        out  2W  result, held until the next accepted load
//   rem_err    out  gcd did not divide op_a exactly; held like lcm
// -----------------------------------------------------------------------------
module lcm_from_gcd #(
    parameter int unsigned W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     op_a,
    input  logic [W-1:0]     op_b,
    input  logic             gcd_valid,
    input  logic [W-1:0]     gcd_in,
    output logic             busy,
    output logic             done,
    output logic [2*W-1:0]   lcm,
    output logic             rem_err
);

    localparam int unsigned CW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_GCD,
        S_DIV,
        S_MUL,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [W-1:0]      r_a;
    logic [W-1:0]      r_b;
    logic [W-1:0]      r_gcd;
    logic [W-1:0]      r_dividend;
    logic [W-1:0]      r_rem;
    logic [W-1:0]      r_quot;
    logic [CW-1:0]     r_cnt;
    logic [2*W-1:0]    r_mcand;
    logic [W-1:0]      r_mplier;
    logic [2*W-1:0]    r_acc;
    logic              r_busy;
    logic              r_done;
    logic [2*W-1:0]    r_lcm;
    logic              r_rem_err;

    logic [W:0]        w_rem_sh;
    logic              w_ge;
    logic [W-1:0]      w_rem_nxt;
    logic [W-1:0]      w_quot_nxt;
    logic [2*W-1:0]    w_acc_nxt;

    // One restoring-divide step and one shift-add step.
    // The shifted remainder is kept W+1 bits wide so a gcd above 2^(W-1)
    // cannot lose the remainder's top bit before the compare.
    always_comb begin
        w_rem_sh   = {r_rem, r_dividend[W-1]};
        w_ge       = (w_rem_sh >= {1'b0, r_gcd});
        w_rem_nxt  = w_ge ? W'(w_rem_sh - {1'b0, r_gcd}) : W'(w_rem_sh);
        w_quot_nxt = {r_quot[W-2:0], w_ge};
        w_acc_nxt  = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    end

    // Control FSM and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_a        <= '0;
            r_b        <= '0;
            r_gcd      <= '0;
            r_dividend <= '0;
            r_rem      <= '0;
            r_quot     <= '0;
            r_cnt      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_lcm      <= '0;
            r_rem_err  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // gcd_valid here belongs to the previous operation: ignored.
                S_IDLE, S_DONE: begin
                    if (load) begin
                        r_a       <= op_a;
                        r_b       <= op_b;
                        r_lcm     <= '0;
                        r_rem_err <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_WAIT_GCD;
                    end else begin
                        r_state   <= S_IDLE;
                    end
                end

                S_WAIT_GCD: begin
                    if (gcd_valid) begin
                        if ((gcd_in == '0) || (r_a == '0) || (r_b == '0)) begin
                            r_lcm     <= '0;
                            r_rem_err <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= S_DONE;
                        end else begin
                            r_gcd      <= gcd_in;
                            r_dividend <= r_a;
                            r_rem      <= '0;
                            r_quot     <= '0;
                            r_cnt      <= CW'(W - 1);
                            r_state    <= S_DIV;
                        end
                    end
                end

                S_DIV: begin
                    r_rem      <= w_rem_nxt;
                    r_quot     <= w_quot_nxt;
                    r_dividend <= {r_dividend[W-2:0], 1'b0};
                    if (r_cnt == '0) begin
                        r_rem_err <= (w_rem_nxt != '0);
                        r_mcand   <= {{W{1'b0}}, w_quot_nxt};
                        r_mplier  <= r_b;
                        r_acc     <= '0;
                        r_cnt     <= CW'(W - 1);
                        r_state   <= S_MUL;
                    end else begin
                        r_cnt     <= r_cnt - CW'(1);
                    end
                end

                S_MUL: begin
                    r_acc    <= w_acc_nxt;
                    r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[W-1:1]};
                    if (r_cnt == '0) begin
                        r_lcm   <= w_acc_nxt;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= r_cnt - CW'(1);
                    end
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign lcm     = r_lcm;
    assign rem_err = r_rem_err;

endmodule
